// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic valid/ready pipeline stage register.
// Holds the stage occupancy encoding, the RV NOP bubble value and the FD payload layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fd_payload_t;

  localparam int FD_W = $bits(fd_payload_t);

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for stage performance monitoring.
// Sticks at all-ones instead of wrapping; cleared only by the async reset.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with a two-entry skid buffer so that in_ready comes from a flop.
// Optional perf counters (stall_cnt, flush_cnt) are present only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_reg: CNT_W must be at least 1");
  end

  stage_state_e      state, state_nx;
  logic [DATA_W-1:0] main_q, main_nx;
  logic [DATA_W-1:0] skid_q, skid_nx;
  logic              ready_q;
  logic              accept;
  logic              fire;

  assign in_ready  = ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & ready_q;
  assign fire      = out_valid & out_ready & ~stall;

  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      // A beat firing this cycle is already delivered; everything else is dropped.
      state_nx = EMPTY;
      main_nx  = BUBBLE_VAL;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nx = ONE;
            main_nx  = in_data;
          end
        end
        ONE: begin
          if (accept && fire) begin
            main_nx = in_data;
          end else if (accept) begin
            state_nx = FULL;
            skid_nx  = in_data;
          end else if (fire) begin
            state_nx = EMPTY;
            main_nx  = BUBBLE_VAL;
          end
        end
        FULL: begin
          if (fire) begin
            state_nx = ONE;
            main_nx  = skid_q;
          end
        end
        default: begin
          state_nx = EMPTY;
          main_nx  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nx;
      main_q  <= main_nx;
      skid_q  <= skid_nx;
      ready_q <= (state_nx != FULL);
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = out_valid & ~fire;
  // Only held beats that fail to leave count as killed.
  assign flush_inc = flush & ((state == FULL) | ((state == ONE) & ~fire));

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a queue-based model.
// Perf counter checks are included when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int             DW  = 32;
  localparam int             CW  = 4;
  localparam logic [DW-1:0]  BUB = RV_NOP;
  localparam int unsigned    SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          stall;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  pipe_stage_reg #(
    .DATA_W     (DW),
    .BUBBLE_VAL (BUB),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  int unsigned   m_stall;
  int unsigned   m_flush;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
    chk({tag, ".out_data"},  64'(out_data),  64'((q.size() > 0) ? q[0] : BUB));
`ifdef PIPE_STAGE_PERF_EN
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`endif
  endtask

  // One clock: drive inputs, advance the model by the stage's transfer rules, then compare.
  task automatic cyc(input string tag, input bit iv, input logic [DW-1:0] d,
                     input bit ordy, input bit stl, input bit fl);
    bit acc, fr;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    stall     = stl;
    flush     = fl;
    acc = iv && (q.size() < 2);
    fr  = (q.size() > 0) && ordy && !stl;
    if ((q.size() > 0) && !fr && (m_stall < SAT)) m_stall++;
    if (fl && ((q.size() == 2) || ((q.size() == 1) && !fr)) && (m_flush < SAT)) m_flush++;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (fr) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    check_outs(tag);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    m_stall = 0; m_flush = 0;
    #12;
    check_outs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // streaming 1,2,3
    cyc("stream1", 1, 32'd1, 1, 0, 0);
    cyc("stream2", 1, 32'd2, 1, 0, 0);
    cyc("stream3", 1, 32'd3, 1, 0, 0);
    cyc("stream4", 0, 32'd0, 1, 0, 0);
    cyc("stream5", 0, 32'd0, 1, 0, 0);

    // backpressure A,B then release
    cyc("bp_a", 1, 32'hA, 0, 0, 0);
    cyc("bp_b", 1, 32'hB, 0, 0, 0);
    cyc("bp_hold", 1, 32'hC, 0, 0, 0);
    cyc("bp_rel1", 0, 32'd0, 1, 0, 0);
    cyc("bp_rel2", 0, 32'd0, 1, 0, 0);
    cyc("bp_rel3", 0, 32'd0, 1, 0, 0);

    // stall while full
    cyc("st_a", 1, 32'hA1, 0, 0, 0);
    cyc("st_b", 1, 32'hB1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("stall", 0, 32'd0, 1, 1, 0);
    cyc("st_rel1", 0, 32'd0, 1, 0, 0);
    cyc("st_rel2", 0, 32'd0, 1, 0, 0);

    // flush while full with an incoming beat
    cyc("fl_a", 1, 32'hA2, 0, 0, 0);
    cyc("fl_b", 1, 32'hB2, 0, 0, 0);
    cyc("flush", 1, 32'hC2, 0, 0, 1);
    cyc("fl_after1", 0, 32'd0, 1, 0, 0);
    cyc("fl_after2", 0, 32'd0, 1, 0, 0);

    // flush in ONE with a firing beat and an incoming one
    cyc("fl1_a", 1, 32'hA3, 0, 0, 0);
    cyc("fl1_fire", 1, 32'hC3, 1, 0, 1);
    cyc("fl1_after", 0, 32'd0, 1, 0, 0);

    // counter saturation: long stall with data held
    cyc("sat_a", 1, 32'hA4, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc("sat", 0, 32'd0, 1, 1, 0);
    cyc("sat_rel1", 0, 32'd0, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          bit'($urandom_range(0, 3) != 0),
          DW'($urandom),
          bit'($urandom_range(0, 3) != 0),
          bit'($urandom_range(0, 4) == 0),
          bit'($urandom_range(0, 15) == 0));
    end

    // async reset while full
    cyc("rst_a", 1, 32'hA5, 0, 0, 0);
    cyc("rst_b", 1, 32'hB5, 0, 0, 0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_stall = 0;
    m_flush = 0;
    check_outs("async_rst");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("post_rst");
    cyc("post_rst_beat", 1, 32'h55, 1, 0, 0);
    cyc("post_rst_out", 0, 32'd0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
